// File: rtl/la_out_arbiter.sv
// la_out_arbiter
//   Owns the 128-bit logic-analyzer output storage and is its only writer.
//   Two requesters (0: host bus bridge, 1: on-chip test sequencer) share
//   write access. Each write updates one 32-bit lane under byte enables.
//   Requesters are granted round-robin, and each write goes through a
//   three-state sequence (one write per 3 cycles).
//
// Ports
//   sys_clk, sys_rst         clock; synchronous active-high reset
//   reqN_valid/ready         handshake for requester N (ready from flops only)
//   reqN_addr                lane select (lane k = la_output[32k+31:32k])
//   reqN_wdata, reqN_sel     write data and byte enables
//   grant                    one-hot owner of current transaction, 0 when idle
//   update_pulse             one-cycle pulse after the storage changes
//   la_output                storage contents (direct from flops)
//
// state  | meaning
// IDLE   | no transaction; arbitrate between pending valids
// ACCEPT | grant held, granted requester sees ready; capture or abort
// COMMIT | apply captured byte-enabled write, advance round-robin
module la_out_arbiter #(
  parameter logic [127:0] RESET_VALUE = 128'd0
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [1:0]   req0_addr,
  input  logic [31:0]  req0_wdata,
  input  logic [3:0]   req0_sel,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [1:0]   req1_addr,
  input  logic [31:0]  req1_wdata,
  input  logic [3:0]   req1_sel,
  output logic [1:0]   grant,
  output logic         update_pulse,
  output logic [127:0] la_output
);

  typedef enum logic [1:0] {IDLE, ACCEPT, COMMIT} state_t;

  state_t        state;
  logic          rr;
  logic [1:0]    grant_q;
  logic [1:0]    hold_addr;
  logic [31:0]   hold_wdata;
  logic [3:0]    hold_sel;
  logic [127:0]  storage;
  logic          update_q;

  logic          win1;
  logic          granted_valid;
  logic [1:0]    granted_addr;
  logic [31:0]   granted_wdata;
  logic [3:0]    granted_sel;

  // With both valid the pointer decides; otherwise the lone requester wins.
  assign win1 = (req0_valid & req1_valid) ? rr : req1_valid;

  assign granted_valid = grant_q[1] ? req1_valid : req0_valid;
  assign granted_addr  = grant_q[1] ? req1_addr  : req0_addr;
  assign granted_wdata = grant_q[1] ? req1_wdata : req0_wdata;
  assign granted_sel   = grant_q[1] ? req1_sel   : req0_sel;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      rr         <= 1'b0;
      grant_q    <= 2'b00;
      hold_addr  <= 2'd0;
      hold_wdata <= 32'd0;
      hold_sel   <= 4'd0;
      storage    <= RESET_VALUE;
      update_q   <= 1'b0;
    end else begin
      update_q <= (state == COMMIT);
      case (state)
        IDLE: begin
          if (req0_valid | req1_valid) begin
            grant_q <= win1 ? 2'b10 : 2'b01;
            state   <= ACCEPT;
          end else begin
            grant_q <= 2'b00;
          end
        end
        ACCEPT: begin
          if (granted_valid) begin
            hold_addr  <= granted_addr;
            hold_wdata <= granted_wdata;
            hold_sel   <= granted_sel;
            state      <= COMMIT;
          end else begin
            // Requester withdrew: no write, pointer untouched.
            grant_q <= 2'b00;
            state   <= IDLE;
          end
        end
        COMMIT: begin
          for (int b = 0; b < 4; b++) begin
            if (hold_sel[b])
              storage[{hold_addr, 2'(b), 3'd0} +: 8] <= hold_wdata[8*b +: 8];
          end
          // Preference moves to the requester that did not just write.
          rr      <= grant_q[0];
          grant_q <= 2'b00;
          state   <= IDLE;
        end
        default: begin
          grant_q <= 2'b00;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign req0_ready   = (state == ACCEPT) & grant_q[0];
  assign req1_ready   = (state == ACCEPT) & grant_q[1];
  assign grant        = grant_q;
  assign update_pulse = update_q;
  assign la_output    = storage;

endmodule
